// File: rtl/upper_tri_operand_streamer.sv
// upper_tri_operand_streamer
// Buffers an upper-triangular matrix supplied in packed row-major form
// (N(N+1)/2 elements) and, on start, replays it as a full NxN element
// stream with zeros below the diagonal, in row- or column-major order.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   load_valid/load_data     packed element input
//   load_ready               block accepts a packed element (LOAD state)
//   full                     all packed elements buffered, awaiting start
//   start, col_major         begin streaming / order select (sampled while full)
//   busy                     streaming in progress
//   out_valid/out_ready      output element handshake
//   out_data/out_row/out_col element M[out_row][out_col]
//   out_last                 final (N*N-th) element of the matrix
module upper_tri_operand_streamer #(
    parameter int unsigned N      = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_valid,
    input  logic [DATA_W-1:0]      load_data,
    output logic                   load_ready,
    output logic                   full,
    input  logic                   start,
    input  logic                   col_major,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [$clog2(N)-1:0]   out_row,
    output logic [$clog2(N)-1:0]   out_col,
    output logic                   out_last
);

    localparam int unsigned T     = N * (N + 1) / 2;
    localparam int unsigned IDX_W = $clog2(T);
    localparam int unsigned RC_W  = $clog2(N);

    typedef enum logic [1:0] {
        S_LOAD,
        S_FULL,
        S_STREAM
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic                colm_q, colm_d;
    logic                load_ready_q, load_ready_d;
    logic                full_q, full_d;
    logic                busy_q, busy_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [RC_W-1:0]     out_row_q, out_row_d;
    logic [RC_W-1:0]     out_col_q, out_col_d;
    logic                out_last_q, out_last_d;

    logic [DATA_W-1:0]   mem_q [T];
    logic                wr_en;

    // Position and packed index of the element following the one presented
    logic [RC_W-1:0]     nxt_row, nxt_col;
    int unsigned         ri, ci, pidx;
    logic [DATA_W-1:0]   nxt_data;

    // Packed buffer; deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[cnt_q] <= load_data;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_LOAD;
            cnt_q        <= '0;
            colm_q       <= 1'b0;
            load_ready_q <= 1'b1;
            full_q       <= 1'b0;
            busy_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            colm_q       <= colm_d;
            load_ready_q <= load_ready_d;
            full_q       <= full_d;
            busy_q       <= busy_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            out_last_q   <= out_last_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        colm_d      = colm_q;
        wr_en       = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_last_d  = out_last_q;
        nxt_row     = out_row_q;
        nxt_col     = out_col_q;
        nxt_data    = '0;
        pidx        = 0;

        // Advance along the selected order, wrapping at the matrix edge
        if (colm_q) begin
            if (out_row_q == RC_W'(N - 1)) begin
                nxt_row = '0;
                nxt_col = out_col_q + RC_W'(1);
            end else begin
                nxt_row = out_row_q + RC_W'(1);
            end
        end else begin
            if (out_col_q == RC_W'(N - 1)) begin
                nxt_col = '0;
                nxt_row = out_row_q + RC_W'(1);
            end else begin
                nxt_col = out_col_q + RC_W'(1);
            end
        end

        // Packed row-major upper-triangle index; lower triangle reads as zero
        ri = 32'(nxt_row);
        ci = 32'(nxt_col);
        if (ci >= ri) begin
            pidx     = ri * N - (ri * (ri - 1)) / 2 + (ci - ri);
            nxt_data = mem_q[IDX_W'(pidx)];
        end

        case (state_q)
            S_LOAD: begin
                if (load_valid && load_ready_q) begin
                    wr_en = 1'b1;
                    if (cnt_q == IDX_W'(T - 1)) begin
                        cnt_d   = '0;
                        state_d = S_FULL;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            S_FULL: begin
                if (start) begin
                    colm_d      = col_major;
                    state_d     = S_STREAM;
                    out_valid_d = 1'b1;
                    out_row_d   = '0;
                    out_col_d   = '0;
                    out_data_d  = mem_q[0];
                    out_last_d  = 1'b0;
                end
            end
            S_STREAM: begin
                if (out_valid_q && out_ready) begin
                    if (out_last_q) begin
                        state_d     = S_LOAD;
                        cnt_d       = '0;
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                        out_row_d   = '0;
                        out_col_d   = '0;
                        out_last_d  = 1'b0;
                    end else begin
                        out_row_d  = nxt_row;
                        out_col_d  = nxt_col;
                        out_data_d = nxt_data;
                        out_last_d = (nxt_row == RC_W'(N - 1)) && (nxt_col == RC_W'(N - 1));
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase

        load_ready_d = (state_d == S_LOAD);
        full_d       = (state_d == S_FULL);
        busy_d       = (state_d == S_STREAM);
    end

    assign load_ready = load_ready_q;
    assign full       = full_q;
    assign busy       = busy_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
    assign out_last   = out_last_q;

endmodule

// File: tb/tb_upper_tri_operand_streamer.sv
// Testbench for upper_tri_operand_streamer (N=4, DATA_W=32).
// Stimulus pushes expected stream elements into a queue; a monitor pops and
// compares them on every output transfer and checks stall stability.
module tb_upper_tri_operand_streamer;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int T  = N * (N + 1) / 2;

    logic          clk;
    logic          rst;
    logic          load_valid;
    logic [DW-1:0] load_data;
    logic          load_ready;
    logic          full;
    logic          start;
    logic          col_major;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    out_row;
    logic [1:0]    out_col;
    logic          out_last;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [1:0]    r;
        logic [1:0]    c;
        logic          l;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] pk [T];
    int            n_checks;
    int            n_fail;
    int            xfers;
    int            rdy_mode;

    upper_tri_operand_streamer #(.N(N), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .full       (full),
        .start      (start),
        .col_major  (col_major),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_last   (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: expand the packed triangle into a full matrix, then walk it
    task automatic push_exp(input logic cm);
        logic [DW-1:0] m [N][N];
        int k;
        exp_t e;
        k = 0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (c >= r) begin
                    m[r][c] = pk[k];
                    k++;
                end else begin
                    m[r][c] = '0;
                end
            end
        end
        for (int a = 0; a < N; a++) begin
            for (int b = 0; b < N; b++) begin
                e.r = cm ? 2'(b) : 2'(a);
                e.c = cm ? 2'(a) : 2'(b);
                e.d = m[e.r][e.c];
                e.l = (e.r == 2'(N - 1)) && (e.c == 2'(N - 1));
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic do_load(input logic gaps, input logic st);
        for (int i = 0; i < T; i++) begin
            load_valid = 1'b1;
            load_data  = pk[i];
            start      = st;
            col_major  = 1'($urandom);
            chk("load_ready_in_load", 32'(load_ready), 32'd1);
            step();
            if (gaps) begin
                load_valid = 1'b0;
                load_data  = $urandom;
                step();
            end
        end
        load_valid = 1'b0;
        start      = 1'b0;
    endtask

    task automatic start_stream(input logic cm);
        col_major = cm;
        start     = 1'b1;
        push_exp(cm);
        step();
        start     = 1'b0;
        col_major = 1'($urandom);
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 400; i++) begin
            if (!busy && !out_valid && exp_q.size() == 0) break;
            step();
        end
        chk("stream_timeout", 32'(i >= 400), 32'd0);
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        chk("busy_end", 32'(busy), 32'd0);
        chk("ld_rdy_end", 32'(load_ready), 32'd1);
    endtask

    // out_ready driver: 0 = always high, 1 = pattern 1,0,0,1, else random
    initial begin
        int ph;
        ph = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
                    ph++;
                end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: scoreboard pop on transfer, stability during stall
    initial begin
        logic stall;
        exp_t prev;
        exp_t e;
        stall = 1'b0;
        prev  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("hold_data", out_data, prev.d);
                    chk("hold_pos", 32'({out_valid, out_row, out_col, out_last}),
                        32'({1'b1, prev.r, prev.c, prev.l}));
                end
                if (out_valid) begin
                    chk("ld_rdy_in_stream", 32'(load_ready), 32'd0);
                    chk("busy_in_stream", 32'(busy), 32'd1);
                    if (out_ready) begin
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_out: got %0h expected none", out_data);
                        end else begin
                            e = exp_q.pop_front();
                            chk("out_data", out_data, e.d);
                            chk("out_row", 32'(out_row), 32'(e.r));
                            chk("out_col", 32'(out_col), 32'(e.c));
                            chk("out_last", 32'(out_last), 32'(e.l));
                        end
                        xfers++;
                    end
                end
                stall = out_valid && !out_ready;
                prev  = {out_data, out_row, out_col, out_last};
            end
        end
    end

    initial begin
        int base;
        n_checks   = 0;
        n_fail     = 0;
        xfers      = 0;
        rdy_mode   = 0;
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        start      = 1'b0;
        col_major  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        rst = 1'b0;
        chk("rst_load_ready", 32'(load_ready), 32'd1);

        // Row-major, no backpressure, no bubbles
        for (int i = 0; i < T; i++) pk[i] = 32'(i + 1);
        do_load(1'b0, 1'b0);
        chk("full_after_load", 32'(full), 32'd1);
        chk("ld_rdy_full", 32'(load_ready), 32'd0);
        start_stream(1'b0);
        for (int i = 0; i < N * N; i++) begin
            chk("no_bubble", 32'(out_valid), 32'd1);
            step();
        end
        chk("valid_after_last", 32'(out_valid), 32'd0);
        chk("busy_after_last", 32'(busy), 32'd0);
        chk("ld_rdy_after_last", 32'(load_ready), 32'd1);
        wait_done();

        // Column-major
        do_load(1'b0, 1'b0);
        start_stream(1'b1);
        wait_done();

        // Backpressure 1,0,0,1
        rdy_mode = 1;
        do_load(1'b0, 1'b0);
        base = xfers;
        start_stream(1'b0);
        wait_done();
        chk("bp_xfers", 32'(xfers - base), 32'd16);
        rdy_mode = 0;

        // Start asserted throughout loading, including the final beat
        do_load(1'b0, 1'b1);
        chk("sdl_full", 32'(full), 32'd1);
        chk("sdl_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("sdl_idle", 32'({busy, out_valid, full}), 32'b001);
        end
        start_stream(1'b0);
        wait_done();

        // Reset after the 6th transfer
        do_load(1'b0, 1'b0);
        base = xfers;
        start_stream(1'b0);
        for (int i = 0; i < 100; i++) begin
            if (xfers - base >= 6) break;
            step();
        end
        chk("xfers_before_rst", 32'(xfers - base), 32'd6);
        rst = 1'b1;
        step();
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_full", 32'(full), 32'd0);
        chk("mrst_ld_rdy", 32'(load_ready), 32'd1);
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < T; i++) pk[i] = 32'(i + 11);
        do_load(1'b0, 1'b0);
        start_stream(1'b0);
        wait_done();

        // Load gaps, dropped beats in FULL and STREAM, random backpressure
        rdy_mode = 2;
        for (int i = 0; i < T; i++) pk[i] = $urandom;
        do_load(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_data  = $urandom;
            chk("ld_rdy_full_drop", 32'({load_ready, full}), 32'b01);
            step();
        end
        start_stream(1'b0);
        for (int i = 0; i < 4; i++) begin
            load_data = $urandom;
            step();
        end
        load_valid = 1'b0;
        wait_done();

        // Randomized matrices, orders and load gaps
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < T; i++) pk[i] = $urandom;
            do_load(1'($urandom), 1'b0);
            start_stream(1'($urandom));
            wait_done();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
